// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output stage.
//   sample_t            signed 16-bit PCM sample
//   stereo_sample_t     {left, right} pair, the FIFO word
//   DAC_BITS            width of each resistor-DAC code
//   AUDIO_MIDSCALE_CODE DAC code for silence
//   to_offset_binary()  signed two's complement -> unsigned offset binary
package audio_pkg;

  localparam int DAC_BITS = 4;
  localparam logic [DAC_BITS-1:0] AUDIO_MIDSCALE_CODE = 4'd8;
  localparam int ERR_BITS = 12;

  typedef logic signed [15:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_sample_t;

  // Flipping the sign bit maps -32768..32767 onto 0..65535, so silence
  // (0) lands on 0x8000, the middle of the DAC range.
  function automatic logic [15:0] to_offset_binary(input sample_t s);
    return {~s[15], s[14:0]};
  endfunction

endpackage

// File: rtl/audio_output_stage_if.sv
// Sample handshake between the APU (master) and the output stage (slave).
//   s_valid  master->slave  sample pair offered
//   s_ready  slave->master  stage can accept a pair
//   s_left   master->slave  signed left sample
//   s_right  master->slave  signed right sample
interface audio_output_stage_if;
  import audio_pkg::*;

  logic    s_valid;
  logic    s_ready;
  sample_t s_left;
  sample_t s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface

// File: rtl/audio_sigma_delta.sv
// One channel of first-order sigma-delta conversion to a 4-bit DAC code.
//   clk     system clock
//   resetn  asynchronous active-low reset
//   cur_i   signed sample currently being played
//   code_o  registered 4-bit DAC code
// The low 12 bits of the offset-binary sample accumulate in a residue and
// carry into the code, so the code averages to u/4096 over time.
module audio_sigma_delta
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  sample_t             cur_i,
  output logic [DAC_BITS-1:0] code_o
);

  logic [ERR_BITS-1:0] err_q, err_d;
  logic [DAC_BITS-1:0] code_q, code_d;
  logic [16:0]         sum;

  always_comb begin
    sum    = {1'b0, to_offset_binary(cur_i)} + {5'b0, err_q};
    err_d  = sum[ERR_BITS-1:0];
    // Only u near full scale plus a residue can reach 16; clip it to 15.
    code_d = (sum[16:12] > 5'd15) ? 4'd15 : sum[15:12];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q  <= '0;
      code_q <= AUDIO_MIDSCALE_CODE;
    end else begin
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  assign code_o = code_q;

endmodule

// File: rtl/audio_output_stage.sv
// Audio output stage: sample FIFO, sample-rate timer, underrun counter and
// two sigma-delta channels driving the board's 4-bit resistor DACs.
//   clk            system clock (25 MHz)
//   resetn         asynchronous active-low reset
//   enable         playback enable; low holds timer at 0 and output at midscale
//   s_if           slave side of the sample handshake
//   audio_l/_r     4-bit DAC codes
//   sample_tick    one-cycle pulse at each sample period boundary
//   underrun_count saturating count of ticks that found the FIFO empty
module audio_output_stage
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = 567,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  audio_output_stage_if.slave  s_if,
  output logic [DAC_BITS-1:0]  audio_l,
  output logic [DAC_BITS-1:0]  audio_r,
  output logic                 sample_tick,
  output logic [15:0]          underrun_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(SAMPLE_DIV);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  stereo_sample_t mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             s_ready_q, s_ready_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [15:0]      underrun_q, underrun_d;
  stereo_sample_t   cur_q, cur_d;
  logic             push, pop;

  assign sample_tick = enable && (tmr_q == TMR_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    push       = s_if.s_valid && s_ready_q;
    // Pop decisions use the pre-edge occupancy: a push landing in the tick
    // cycle into an empty FIFO is not bypassed and the tick is an underrun.
    pop        = sample_tick && (count_q != '0);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tmr_d      = tmr_q;
    underrun_d = underrun_q;
    cur_d      = cur_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Ready is registered from the next occupancy, so it drops in the same
    // edge that fills the last entry and a push while full cannot happen.
    s_ready_d = (count_d != CNT_FULL);

    if (!enable)          tmr_d = '0;
    else if (sample_tick) tmr_d = '0;
    else                  tmr_d = tmr_q + TMR_W'(1);

    if (sample_tick && (count_q == '0) && (underrun_q != 16'hFFFF))
      underrun_d = underrun_q + 16'd1;

    // Disabled playback forces silence; an underrun simply keeps cur_q.
    if (!enable)  cur_d = '0;
    else if (pop) cur_d = mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      s_ready_q  <= 1'b1;
      tmr_q      <= '0;
      underrun_q <= '0;
      cur_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      s_ready_q  <= s_ready_d;
      tmr_q      <= tmr_d;
      underrun_q <= underrun_d;
      cur_q      <= cur_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define
  // which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{left: s_if.s_left, right: s_if.s_right};
  end

  assign s_if.s_ready   = s_ready_q;
  assign underrun_count = underrun_q;

  audio_sigma_delta u_sd_left (
    .clk    (clk),
    .resetn (resetn),
    .cur_i  (cur_q.left),
    .code_o (audio_l)
  );

  audio_sigma_delta u_sd_right (
    .clk    (clk),
    .resetn (resetn),
    .cur_i  (cur_q.right),
    .code_o (audio_r)
  );

endmodule

// File: tb/tb_audio_output_stage.sv
// Directed bench for audio_output_stage. Inputs are driven 1 ns after the
// rising edge, outputs are sampled on the falling edge. Cycle 0 is the first
// cycle with enable high; ticks fall at 567*k + 566.
module tb_audio_output_stage;
  import audio_pkg::*;

  localparam int SAMPLE_DIV = 567;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  audio_l, audio_r;
  logic        sample_tick;
  logic [15:0] underrun_count;

  audio_output_stage_if s_if ();

  audio_output_stage #(.SAMPLE_DIV(SAMPLE_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .s_if           (s_if),
    .audio_l        (audio_l),
    .audio_r        (audio_r),
    .sample_tick    (sample_tick),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  sample_t pl [5];
  sample_t pr [5];

  task automatic to_start();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  function automatic logic exp_tick(input int c);
    return (c % SAMPLE_DIV) == SAMPLE_DIV - 1;
  endfunction

  // Ticks 0..4 pop the five prefilled pairs; every later tick underruns.
  function automatic int exp_under(input int c);
    return (c / SAMPLE_DIV > 5) ? c / SAMPLE_DIV - 5 : 0;
  endfunction

  task automatic test_reset();
    int ticks = 0, bad_l = 0, bad_r = 0, bad_rdy = 0;
    s_if.s_valid = 1'b0;
    s_if.s_left  = '0;
    s_if.s_right = '0;
    resetn = 1'b0;
    enable = 1'b0;
    repeat (3) to_start();
    resetn = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      to_sample();
      if (sample_tick)      ticks++;
      if (audio_l !== 4'd8) bad_l++;
      if (audio_r !== 4'd8) bad_r++;
      if (s_if.s_ready !== 1'b1) bad_rdy++;
      to_start();
    end
    total++; if (ticks !== 0)   begin bad++; $display("FAIL idle_ticks: got %0d want 0", ticks); end
    total++; if (bad_l !== 0)   begin bad++; $display("FAIL idle_audio_l: %0d cycles not 8", bad_l); end
    total++; if (bad_r !== 0)   begin bad++; $display("FAIL idle_audio_r: %0d cycles not 8", bad_r); end
    total++; if (bad_rdy !== 0) begin bad++; $display("FAIL idle_ready: %0d cycles not 1", bad_rdy); end
    total++; if (underrun_count !== 16'd0) begin bad++; $display("FAIL idle_underrun: got %0d want 0", underrun_count); end
  endtask

  task automatic test_prefill_backpressure();
    int not_ready = 0, held_bad = 0;
    for (int i = 0; i < 4; i++) begin
      s_if.s_valid = 1'b1;
      s_if.s_left  = pl[i];
      s_if.s_right = pr[i];
      to_sample();
      if (s_if.s_ready !== 1'b1) not_ready++;
      to_start();
    end
    // Fifth pair stays offered; it may only be taken after the first tick.
    s_if.s_left  = pl[4];
    s_if.s_right = pr[4];
    for (int c = 0; c < 10; c++) begin
      to_sample();
      if (s_if.s_ready !== 1'b0) held_bad++;
      to_start();
    end
    total++; if (not_ready !== 0) begin bad++; $display("FAIL prefill_accept: %0d of 4 pushes refused", not_ready); end
    total++; if (held_bad !== 0)  begin bad++; $display("FAIL full_backpressure: ready high in %0d cycles, want 0", held_bad); end
  endtask

  task automatic test_tick_pop();
    int first_tick = -1, tick_bad = 0, rdy_bad = 0, l_bad = 0, r_bad = 0;
    enable = 1'b1;
    cyc = 0;
    for (int c = 0; c <= 567; c++) begin
      to_sample();
      if (sample_tick && first_tick < 0) first_tick = c;
      if (sample_tick !== exp_tick(c)) tick_bad++;
      if (s_if.s_ready !== ((c <= 566) ? 1'b0 : 1'b1)) rdy_bad++;
      to_start();
      cyc++;
    end
    s_if.s_valid = 1'b0;
    for (int c = 568; c <= 1134; c++) begin
      to_sample();
      if (audio_l !== 4'd15) l_bad++;
      if (audio_r !== 4'd0)  r_bad++;
      if (sample_tick !== exp_tick(c)) tick_bad++;
      to_start();
      cyc++;
    end
    total++; if (first_tick !== 566) begin bad++; $display("FAIL first_tick_cycle: got %0d want 566", first_tick); end
    total++; if (tick_bad !== 0) begin bad++; $display("FAIL tick_pattern: %0d wrong cycles, want 0", tick_bad); end
    total++; if (rdy_bad !== 0)  begin bad++; $display("FAIL ready_after_pop: %0d wrong cycles, want 0", rdy_bad); end
    total++; if (l_bad !== 0)    begin bad++; $display("FAIL fullscale_l: %0d cycles not 15", l_bad); end
    total++; if (r_bad !== 0)    begin bad++; $display("FAIL zeroscale_r: %0d cycles not 0", r_bad); end
  endtask

  task automatic test_playback_sequence();
    int l_bad = 0, r_bad = 0, tick_bad = 0, u_bad = 0;
    logic [3:0] el, er;
    for (int c = 1135; c <= 2835; c++) begin
      case ((c - 568) / SAMPLE_DIV)
        1:       begin el = 4'd8;  er = 4'd8;  end
        2:       begin el = 4'd12; er = 4'd4;  end
        default: begin el = 4'd0;  er = 4'd15; end
      endcase
      to_sample();
      if (audio_l !== el) l_bad++;
      if (audio_r !== er) r_bad++;
      if (sample_tick !== exp_tick(c)) tick_bad++;
      if (underrun_count !== 16'(exp_under(c))) u_bad++;
      to_start();
      cyc++;
    end
    total++; if (l_bad !== 0)    begin bad++; $display("FAIL sequence_l: %0d wrong cycles, want 0", l_bad); end
    total++; if (r_bad !== 0)    begin bad++; $display("FAIL sequence_r: %0d wrong cycles, want 0", r_bad); end
    total++; if (tick_bad !== 0) begin bad++; $display("FAIL sequence_ticks: %0d wrong cycles, want 0", tick_bad); end
    total++; if (u_bad !== 0)    begin bad++; $display("FAIL sequence_underrun: %0d wrong cycles, want 0", u_bad); end
  endtask

  // Last pair L=0x0800 is held by underruns for a full 4096-cycle window.
  task automatic test_sigma_delta_underrun();
    int sum_l = 0, alt_bad = 0, r_bad = 0, u_bad = 0, tick_bad = 0;
    logic [3:0] prev = 4'hx;
    for (int c = 2836; c < 2836 + 4096; c++) begin
      to_sample();
      sum_l += int'(audio_l);
      if ((audio_l !== 4'd8 && audio_l !== 4'd9) || audio_l === prev) alt_bad++;
      prev = audio_l;
      if (audio_r !== 4'd8) r_bad++;
      if (sample_tick !== exp_tick(c)) tick_bad++;
      if (underrun_count !== 16'(exp_under(c))) u_bad++;
      to_start();
      cyc++;
    end
    total++; if (sum_l !== 34816) begin bad++; $display("FAIL sd_mean_sum: got %0d want 34816", sum_l); end
    total++; if (alt_bad !== 0)   begin bad++; $display("FAIL sd_alternate: %0d wrong cycles, want 0", alt_bad); end
    total++; if (r_bad !== 0)     begin bad++; $display("FAIL hold_r: %0d cycles not 8", r_bad); end
    total++; if (tick_bad !== 0)  begin bad++; $display("FAIL hold_ticks: %0d wrong cycles, want 0", tick_bad); end
    total++; if (u_bad !== 0)     begin bad++; $display("FAIL underrun_steps: %0d wrong cycles, want 0", u_bad); end
    total++; if (underrun_count !== 16'd7) begin bad++; $display("FAIL underrun_final: got %0d want 7", underrun_count); end
  endtask

  task automatic test_reset_mid_playback();
    int push_bad = 0, a_bad = 0, tick_bad = 0, rdy_bad = 0, first_tick = -1;
    for (int q = 0; q < 4; q++) begin
      s_if.s_valid = 1'b1;
      s_if.s_left  = 16'h4000;
      s_if.s_right = 16'h4000;
      to_sample();
      if (s_if.s_ready !== 1'b1) push_bad++;
      to_start();
      cyc++;
    end
    s_if.s_valid = 1'b0;
    while (cyc < 7372) begin
      to_start();
      cyc++;
    end
    to_sample();
    total++; if (push_bad !== 0) begin bad++; $display("FAIL refill_accept: %0d pushes refused", push_bad); end
    total++; if (audio_l !== 4'd12 || audio_r !== 4'd12) begin bad++; $display("FAIL pre_reset_audio: got %0d/%0d want 12/12", audio_l, audio_r); end
    total++; if (underrun_count !== 16'd7) begin bad++; $display("FAIL pre_reset_underrun: got %0d want 7", underrun_count); end
    to_start();
    resetn = 1'b0;
    #1;
    total++; if (audio_l !== 4'd8 || audio_r !== 4'd8) begin bad++; $display("FAIL reset_audio: got %0d/%0d want 8/8", audio_l, audio_r); end
    total++; if (underrun_count !== 16'd0) begin bad++; $display("FAIL reset_underrun: got %0d want 0", underrun_count); end
    total++; if (s_if.s_ready !== 1'b1 || sample_tick !== 1'b0) begin bad++; $display("FAIL reset_ready_tick: got %b/%b want 1/0", s_if.s_ready, sample_tick); end
    to_start();
    to_start();
    resetn = 1'b1;
    // FIFO must be empty: the first tick underruns and output stays silent.
    for (int c = 0; c <= 567; c++) begin
      to_sample();
      if (sample_tick && first_tick < 0) first_tick = c;
      if (sample_tick !== exp_tick(c)) tick_bad++;
      if (audio_l !== 4'd8 || audio_r !== 4'd8) a_bad++;
      if (s_if.s_ready !== 1'b1) rdy_bad++;
      if (c < 567) to_start();
    end
    total++; if (first_tick !== 566) begin bad++; $display("FAIL post_reset_tick: got %0d want 566", first_tick); end
    total++; if (tick_bad !== 0) begin bad++; $display("FAIL post_reset_ticks: %0d wrong cycles, want 0", tick_bad); end
    total++; if (a_bad !== 0)    begin bad++; $display("FAIL post_reset_audio: %0d cycles not 8/8", a_bad); end
    total++; if (rdy_bad !== 0)  begin bad++; $display("FAIL post_reset_ready: %0d cycles not 1", rdy_bad); end
    total++; if (underrun_count !== 16'd1) begin bad++; $display("FAIL post_reset_underrun: got %0d want 1", underrun_count); end
    to_start();
  endtask

  // The counter is preloaded near the top so saturation is reached in a
  // few ticks instead of 65535 sample periods.
  task automatic test_underrun_saturation();
    int u_bad = 0, e;
    enable = 1'b0;
    force dut.underrun_q = 16'hFFFC;
    to_start();
    release dut.underrun_q;
    to_sample();
    total++; if (underrun_count !== 16'hFFFC) begin bad++; $display("FAIL sat_preload: got %h want fffc", underrun_count); end
    to_start();
    enable = 1'b1;
    for (int c = 0; c <= 4 * SAMPLE_DIV; c++) begin
      e = 16'hFFFC + c / SAMPLE_DIV;
      if (e > 16'hFFFF) e = 16'hFFFF;
      to_sample();
      if (underrun_count !== 16'(e)) u_bad++;
      to_start();
    end
    total++; if (u_bad !== 0) begin bad++; $display("FAIL sat_steps: %0d wrong cycles, want 0", u_bad); end
    total++; if (underrun_count !== 16'hFFFF) begin bad++; $display("FAIL sat_final: got %h want ffff", underrun_count); end
  endtask

  initial begin
    pl[0] = 16'h7FFF; pr[0] = 16'h8000;
    pl[1] = 16'h0000; pr[1] = 16'h0000;
    pl[2] = 16'h4000; pr[2] = 16'hC000;
    pl[3] = 16'h8000; pr[3] = 16'h7FFF;
    pl[4] = 16'h0800; pr[4] = 16'h0000;
    test_reset();
    test_prefill_backpressure();
    test_tick_pop();
    test_playback_sequence();
    test_sigma_delta_underrun();
    test_reset_mid_playback();
    test_underrun_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
